// File: rtl/adc_peak_detect_if.sv
// Sample, parameter and result signals of adc_peak_detect.
// The master drives samples and controls; the slave (the detector) drives the results.
interface adc_peak_detect_if;
    logic [13:0] adc_data;
    logic        adc_valid;
    logic        param_wen;
    logic [31:0] window_len;
    logic        start;
    logic        busy;
    logic        done;
    logic [13:0] vmax;
    logic [13:0] vmin;
    logic [14:0] vpp;
    logic [31:0] zc_count;

    modport master (
        output adc_data, adc_valid, param_wen, window_len, start,
        input  busy, done, vmax, vmin, vpp, zc_count
    );

    modport slave (
        input  adc_data, adc_valid, param_wen, window_len, start,
        output busy, done, vmax, vmin, vpp, zc_count
    );
endinterface

// File: rtl/adc_peak_detect.sv
// Windowed peak/trough/peak-to-peak detector for 14-bit offset-binary ADC samples.
// Define ADC_PEAK_DETECT_ZC_EN to count rising zero crossings; otherwise zc_count reads 0.
module adc_peak_detect (
    input logic              clk,
    input logic              rstn,
    adc_peak_detect_if.slave bus
);
    typedef enum logic [1:0] {StIdle, StMeasure, StDone} state_e;

    localparam logic signed [13:0] SampleMin = 14'h2000;
    localparam logic signed [13:0] SampleMax = 14'h1fff;

    state_e             state_q, state_d;
    logic [31:0]        win_buf_q, win_buf_d;
    logic [31:0]        active_len_q, active_len_d;
    logic [31:0]        cnt_q, cnt_d;
    logic signed [13:0] run_max_q, run_max_d;
    logic signed [13:0] run_min_q, run_min_d;
    logic signed [13:0] vmax_q, vmax_d;
    logic signed [13:0] vmin_q, vmin_d;
    logic [14:0]        vpp_q, vpp_d;

    logic signed [13:0] sample;
    logic signed [13:0] new_max, new_min;
    logic [31:0]        cnt_inc;
    logic               sample_acc, last_sample;

    // Offset binary to two's complement: flip the MSB.
    assign sample      = {~bus.adc_data[13], bus.adc_data[12:0]};
    assign cnt_inc     = cnt_q + 32'd1;
    assign sample_acc  = (state_q == StMeasure) && bus.adc_valid;
    assign last_sample = sample_acc && (cnt_inc == active_len_q);

    always_comb begin
        state_d      = state_q;
        win_buf_d    = win_buf_q;
        active_len_d = active_len_q;
        cnt_d        = cnt_q;
        run_max_d    = run_max_q;
        run_min_d    = run_min_q;
        vmax_d       = vmax_q;
        vmin_d       = vmin_q;
        vpp_d        = vpp_q;
        new_max      = (sample > run_max_q) ? sample : run_max_q;
        new_min      = (sample < run_min_q) ? sample : run_min_q;

        // A zero-length window would never finish, so it is stored as one sample.
        if (bus.param_wen) begin
            win_buf_d = (bus.window_len == 32'd0) ? 32'd1 : bus.window_len;
        end

        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    state_d      = StMeasure;
                    active_len_d = win_buf_q;
                    cnt_d        = 32'd0;
                    run_max_d    = SampleMin;
                    run_min_d    = SampleMax;
                end
            end
            StMeasure: begin
                if (sample_acc) begin
                    cnt_d     = cnt_inc;
                    run_max_d = new_max;
                    run_min_d = new_min;
                    if (last_sample) begin
                        state_d = StDone;
                        vmax_d  = new_max;
                        vmin_d  = new_min;
                        // Sign-extend to 15 bits so full scale (8191 - -8192) cannot overflow.
                        vpp_d   = {new_max[13], new_max} - {new_min[13], new_min};
                    end
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= StIdle;
            win_buf_q    <= 32'd1;
            active_len_q <= 32'd1;
            cnt_q        <= 32'd0;
            run_max_q    <= SampleMin;
            run_min_q    <= SampleMax;
            vmax_q       <= '0;
            vmin_q       <= '0;
            vpp_q        <= '0;
        end else begin
            state_q      <= state_d;
            win_buf_q    <= win_buf_d;
            active_len_q <= active_len_d;
            cnt_q        <= cnt_d;
            run_max_q    <= run_max_d;
            run_min_q    <= run_min_d;
            vmax_q       <= vmax_d;
            vmin_q       <= vmin_d;
            vpp_q        <= vpp_d;
        end
    end

`ifdef ADC_PEAK_DETECT_ZC_EN
    logic [31:0] zc_cnt_q, zc_cnt_d;
    logic [31:0] zc_out_q, zc_out_d;
    logic        prev_neg_q, prev_neg_d;
    logic [31:0] zc_next;

    // prev_neg is cleared at start, so the first sample of a window can never count.
    always_comb begin
        zc_cnt_d   = zc_cnt_q;
        zc_out_d   = zc_out_q;
        prev_neg_d = prev_neg_q;
        zc_next    = zc_cnt_q + {31'd0, prev_neg_q & ~sample[13]};
        if (state_q == StIdle && bus.start) begin
            zc_cnt_d   = 32'd0;
            prev_neg_d = 1'b0;
        end else if (sample_acc) begin
            zc_cnt_d   = zc_next;
            prev_neg_d = sample[13];
            if (last_sample) begin
                zc_out_d = zc_next;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            zc_cnt_q   <= 32'd0;
            zc_out_q   <= 32'd0;
            prev_neg_q <= 1'b0;
        end else begin
            zc_cnt_q   <= zc_cnt_d;
            zc_out_q   <= zc_out_d;
            prev_neg_q <= prev_neg_d;
        end
    end

    assign bus.zc_count = zc_out_q;
`else
    assign bus.zc_count = 32'd0;
`endif

    assign bus.busy = (state_q != StIdle);
    assign bus.done = (state_q == StDone);
    assign bus.vmax = vmax_q;
    assign bus.vmin = vmin_q;
    assign bus.vpp  = vpp_q;
endmodule

// File: tb/tb_adc_peak_detect.sv
// Scoreboard bench for adc_peak_detect: expected results are queued at start, popped on done.
// Zero-crossing expectations follow ADC_PEAK_DETECT_ZC_EN.
module tb_adc_peak_detect;
    logic clk = 1'b0;
    logic rstn;

    adc_peak_detect_if bus ();

    adc_peak_detect dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    always #5 clk = ~clk;

`ifdef ADC_PEAK_DETECT_ZC_EN
    localparam bit ZcEn = 1'b1;
`else
    localparam bit ZcEn = 1'b0;
`endif

    typedef struct {
        int     vmax;
        int     vmin;
        int     vpp;
        longint zc;
    } exp_t;

    exp_t        exp_q[$];
    logic [13:0] smp_q[$];
    int          total = 0;
    int          bad   = 0;

    function automatic void check(input string name, input longint act, input longint req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d", name, act, req);
        end
    endfunction

    function automatic longint zc_exp(input int n);
        return ZcEn ? longint'(n) : 64'd0;
    endfunction

    task automatic push_exp(input int mx, input int mn, input int pp, input longint zc);
        exp_t e;
        e.vmax = mx;
        e.vmin = mn;
        e.vpp  = pp;
        e.zc   = zc;
        exp_q.push_back(e);
    endtask

    // Monitor: every done pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        exp_t e;
        if (rstn === 1'b1 && bus.done === 1'b1) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: got a done pulse, want none");
            end else begin
                e = exp_q.pop_front();
                check("sb_vmax", longint'($signed(bus.vmax)), longint'(e.vmax));
                check("sb_vmin", longint'($signed(bus.vmin)), longint'(e.vmin));
                check("sb_vpp", longint'(bus.vpp), longint'(e.vpp));
                check("sb_zc", longint'(bus.zc_count), e.zc);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_len(input logic [31:0] len);
        bus.param_wen  = 1'b1;
        bus.window_len = len;
        step();
        bus.param_wen  = 1'b0;
    endtask

    task automatic do_start(input string name);
        check({name, "_idle_busy"}, longint'(bus.busy), 0);
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        check({name, "_start_busy"}, longint'(bus.busy), 1);
    endtask

    task automatic run_window(input string name, input int gap);
        for (int i = 0; i < smp_q.size(); i++) begin
            if (i != 0) repeat (gap) step();
            bus.adc_valid = 1'b1;
            bus.adc_data  = smp_q[i];
            step();
            bus.adc_valid = 1'b0;
        end
        @(negedge clk);
        check({name, "_done"}, longint'(bus.done), 1);
        check({name, "_done_busy"}, longint'(bus.busy), 1);
        @(negedge clk);
        check({name, "_done_drop"}, longint'(bus.done), 0);
        check({name, "_busy_drop"}, longint'(bus.busy), 0);
        step();
    endtask

    task automatic check_zero(input string name);
        check({name, "_busy"}, longint'(bus.busy), 0);
        check({name, "_done"}, longint'(bus.done), 0);
        check({name, "_vmax"}, longint'(bus.vmax), 0);
        check({name, "_vmin"}, longint'(bus.vmin), 0);
        check({name, "_vpp"}, longint'(bus.vpp), 0);
        check({name, "_zc"}, longint'(bus.zc_count), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "bench timed out");
    end

    initial begin
        rstn           = 1'b0;
        bus.adc_data   = '0;
        bus.adc_valid  = 1'b0;
        bus.param_wen  = 1'b0;
        bus.window_len = '0;
        bus.start      = 1'b0;
        #12;
        check_zero("rst");
        step();
        rstn = 1'b1;
        step();

        // Continuous window of four.
        load_len(32'd4);
        push_exp(1000, -1000, 2000, zc_exp(1));
        do_start("t1");
        smp_q = '{14'd8192, 14'd9192, 14'd7192, 14'd8692};
        run_window("t1", 0);

        // Gapped samples at full scale.
        load_len(32'd3);
        push_exp(8191, -8192, 16383, zc_exp(1));
        do_start("t2");
        smp_q = '{14'd0, 14'd16383, 14'd8192};
        run_window("t2", 2);

        // start and param_wen mid-window must not disturb the running window.
        load_len(32'd2);
        push_exp(100, -50, 150, zc_exp(0));
        do_start("t3a");
        bus.adc_valid  = 1'b1;
        bus.adc_data   = 14'd8292;
        bus.start      = 1'b1;
        bus.param_wen  = 1'b1;
        bus.window_len = 32'd10;
        step();
        bus.adc_valid  = 1'b0;
        bus.start      = 1'b0;
        bus.param_wen  = 1'b0;
        check("t3_busy_kept", longint'(bus.busy), 1);
        smp_q = '{14'd8142};
        run_window("t3a", 0);
        load_len(32'd10);
        check("t3_hold_vmax", longint'($signed(bus.vmax)), 100);
        check("t3_hold_vpp", longint'(bus.vpp), 150);
        push_exp(50, -40, 90, zc_exp(1));
        do_start("t3b");
        check("t3_hold_vmin", longint'($signed(bus.vmin)), -50);
        smp_q.delete();
        for (int k = 0; k < 10; k++) smp_q.push_back(14'(8152 + 10 * k));
        run_window("t3b", 0);

        // Reset mid-window aborts with no done pulse.
        load_len(32'd5);
        do_start("t4");
        bus.adc_valid = 1'b1;
        bus.adc_data  = 14'd9000;
        step();
        bus.adc_data  = 14'd7000;
        step();
        bus.adc_valid = 1'b0;
        rstn = 1'b0;
        #1;
        check_zero("t4_rst");
        step();
        step();
        rstn = 1'b1;
        step();
        check_zero("t4_post");
        load_len(32'd0);
        push_exp(8, 8, 0, zc_exp(0));
        do_start("t4b");
        smp_q = '{14'd8200};
        run_window("t4b", 0);

        // start with param_wen in the same idle cycle uses the old length (8).
        load_len(32'd8);
        push_exp(108, -192, 300, zc_exp(4));
        bus.start      = 1'b1;
        bus.param_wen  = 1'b1;
        bus.window_len = 32'd2;
        step();
        bus.start      = 1'b0;
        bus.param_wen  = 1'b0;
        check("t5_start_busy", longint'(bus.busy), 1);
        smp_q = '{14'd8000, 14'd8300, 14'd8000, 14'd8300,
                  14'd8000, 14'd8300, 14'd8000, 14'd8300};
        run_window("t5", 0);

        repeat (3) step();
        check("sb_drained", longint'(exp_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/adc_peak_detect.md
ADC_PEAK_DETECT -- requirements
Module: adc_peak_detect

Interface
REQ-001 SHALL have port: clk  input  1  single system clock; all logic on rising edge.
REQ-002 SHALL have port: rstn  input  1  reset, asynchronous assert, active-low.
REQ-003 SHALL have port: adc_data  input  14  ADC sample, offset binary (8192 = 0 V).
REQ-004 SHALL have port: adc_valid  input  1  adc_data qualifier, one sample per high cycle.
REQ-005 SHALL have port: param_wen  input  1  loads window_len into window buffer.
REQ-006 SHALL have port: window_len  input  32  samples per measurement.
REQ-007 SHALL have port: start  input  1  single-cycle measurement request.
REQ-008 SHALL have port: busy  output  1  high from accepted start through done cycle.
REQ-009 SHALL have port: done  output  1  one-cycle pulse, results valid.
REQ-010 SHALL have port: vmax  output  14  signed maximum of last window.
REQ-011 SHALL have port: vmin  output  14  signed minimum of last window.
REQ-012 SHALL have port: vpp  output  15  unsigned vmax - vmin.
REQ-013 SHALL have port: zc_count  output  32  rising zero crossings in last window.

Function
REQ-014 SHALL convert each sample to signed by inverting adc_data[13] (8192 -> 0, 0 -> -8192, 16383 -> 8191).
REQ-015 SHALL hold window buffer; param_wen loads it any cycle, including while busy; window_len of 0 stored as 1.
REQ-016 SHALL run FSM IDLE -> MEASURE -> DONE -> IDLE.
REQ-017 IDLE: start=1 SHALL copy window buffer to active length, clear sample counter, set running max to -8192, running min to 8191, go MEASURE, assert busy next cycle.
REQ-018 MEASURE: each adc_valid cycle SHALL update running max/min with the converted sample and increment counter; cycles without adc_valid change nothing.
REQ-019 MEASURE: when accepted sample makes counter equal active length, SHALL go DONE, loading vmax/vmin/vpp with totals including that sample.
REQ-020 DONE: SHALL assert done for exactly one cycle (one clk after last sample accepted), then IDLE with busy low next cycle.
REQ-021 start while busy SHALL be ignored; start and param_wen in same IDLE cycle SHALL use the old buffer value.
REQ-022 vmax/vmin/vpp/zc_count SHALL hold their values until the next DONE; param_wen and start do not change them.
REQ-023 vpp SHALL be computed at 15 bits without overflow (max 16383 for full-scale).
REQ-024 Counter SHALL be 32 bits; window_len 0xFFFFFFFF SHALL complete without wrap.

Reset
REQ-025 rstn low SHALL immediately force IDLE, busy=0, done=0, vmax=0, vmin=0, vpp=0, zc_count=0, window buffer=1, counter=0.
REQ-026 Reset during MEASURE SHALL abort measurement; no done pulse; results stay 0.
REQ-027 First start after reset release SHALL be accepted normally.

Configuration
REQ-028 Macro ADC_PEAK_DETECT_ZC_EN defined SHALL enable zero-crossing counting: within MEASURE, a valid sample >= 0 whose previous valid sample in the same window was < 0 increments a 32-bit count, loaded to zc_count at DONE; first sample of a window never counts.
REQ-029 Without ADC_PEAK_DETECT_ZC_EN, zc_count SHALL remain present and tied to 0; all other behaviour identical.

Verification
REQ-030 window_len=4, start, samples 8192,9192,7192,8692 continuous -> done 1 cycle after 4th, vmax=1000, vmin=-1000, vpp=2000, busy low cycle after done.
REQ-031 window_len=3, adc_valid gapped (1 valid every 3 cycles), samples 0,16383,8192 -> vmax=8191, vmin=-8192, vpp=16383.
REQ-032 start again mid-MEASURE and param_wen window_len=10 mid-MEASURE -> current window completes at old length; next start runs 10 samples.
REQ-033 rstn low mid-MEASURE -> busy, done, outputs 0 immediately; no done pulse; then window_len=0, start, one sample 8200 -> done after 1 sample, vmax=vmin=8, vpp=0.
REQ-034 ADC_PEAK_DETECT_ZC_EN defined, window_len=8, samples 8000,8300,8000,8300,8000,8300,8000,8300 -> zc_count=4; macro undefined, same stimulus -> zc_count=0, vpp=300.
